// File: rtl/conv3_sched_pkg.sv
// Shared types and helpers for the conv3 filter scheduler.
// Optional build macro used by the scheduler: CONV3_SCHED_PERF_EN.
package conv3_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } sched_state_t;

    // Counter width that stays >= 1 even for a single-entry range.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Packed width of a {valid,ch,pix} tag; the struct itself is declared
    // where the channel/pixel widths are known.
    function automatic int tag_w(input int ch_w, input int pix_w);
        return 1 + ch_w + pix_w;
    endfunction

endpackage

// File: rtl/conv3_filter_sched_if.sv
// Window-stream, datapath-launch and result-label signals of the conv3 scheduler.
interface conv3_filter_sched_if #(
    parameter int CH_W  = 6,
    parameter int PIX_W = 4
);
    logic             win_valid;
    logic             win_ready;
    logic             dp_valid;
    logic             dp_bubble;
    logic [CH_W-1:0]  wt_addr;
    logic             res_valid;
    logic [CH_W-1:0]  res_ch;
    logic [PIX_W-1:0] res_pix;

    modport master (
        input  win_valid,
        output win_ready, dp_valid, dp_bubble, wt_addr,
        output res_valid, res_ch, res_pix
    );

    modport slave (
        output win_valid,
        input  win_ready, dp_valid, dp_bubble, wt_addr,
        input  res_valid, res_ch, res_pix
    );
endinterface

// File: rtl/conv3_tag_pipe.sv
// Tag shift register mirroring the shared filter datapath; advances only on enable.
module conv3_tag_pipe #(
    parameter int STAGES = 9,
    parameter int TAG_W  = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic [TAG_W-1:0] tag_in,
    output logic [TAG_W-1:0] tag_out
);

    logic [TAG_W-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
        end else if (shift_en) begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign tag_out = stage_q[STAGES-1];

endmodule

// File: rtl/conv3_filter_sched.sv
// Sequences one shared conv3 filter datapath over all output channels per window.
// Build macro CONV3_SCHED_PERF_EN adds the stall_cnt performance counter.
module conv3_filter_sched
    import conv3_sched_pkg::*;
#(
    parameter int NUM_FILTERS = 64,
    parameter int FRAME_PIX   = 16,
    parameter int PIPE_LAT    = 9,
    localparam int CH_W  = cnt_w(NUM_FILTERS),
    localparam int PIX_W = cnt_w(FRAME_PIX)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    conv3_filter_sched_if.master bus,
    output logic                 busy,
    output logic                 frame_done
`ifdef CONV3_SCHED_PERF_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    localparam int FL_W = cnt_w(PIPE_LAT);
    localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_FILTERS - 1);
    localparam logic [PIX_W-1:0] LAST_PIX   = PIX_W'(FRAME_PIX - 1);
    localparam logic [FL_W-1:0]  LAST_FLUSH = FL_W'(PIPE_LAT - 1);

    typedef struct packed {
        logic             valid;
        logic [CH_W-1:0]  ch;
        logic [PIX_W-1:0] pix;
    } tag_t;

    sched_state_t     state, state_d;
    logic [CH_W-1:0]  filt_cnt, filt_d;
    logic [PIX_W-1:0] pix_cnt, pix_d;
    logic [FL_W-1:0]  flush_cnt, flush_d;
    logic             launch, win_ready, dp_valid, dp_bubble, done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            filt_cnt  <= '0;
            pix_cnt   <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_d;
            filt_cnt  <= filt_d;
            pix_cnt   <= pix_d;
            flush_cnt <= flush_d;
        end
    end

    always_comb begin
        state_d   = state;
        filt_d    = filt_cnt;
        pix_d     = pix_cnt;
        flush_d   = flush_cnt;
        launch    = 1'b0;
        win_ready = 1'b0;
        dp_valid  = 1'b0;
        dp_bubble = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    filt_d  = '0;
                    pix_d   = '0;
                end
            end
            RUN: begin
                // A stalled window freezes both the counters and the datapath.
                if (bus.win_valid) begin
                    launch   = 1'b1;
                    dp_valid = 1'b1;
                    if (filt_cnt == LAST_CH) begin
                        win_ready = 1'b1;
                        filt_d    = '0;
                        if (pix_cnt == LAST_PIX) begin
                            pix_d   = '0;
                            flush_d = '0;
                            state_d = FLUSH;
                        end else begin
                            pix_d = pix_cnt + PIX_W'(1);
                        end
                    end else begin
                        filt_d = filt_cnt + CH_W'(1);
                    end
                end
            end
            FLUSH: begin
                dp_valid  = 1'b1;
                dp_bubble = 1'b1;
                if (flush_cnt == LAST_FLUSH) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    flush_d = flush_cnt + FL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---- stage p0: tag enters alongside the datapath launch ----
    tag_t tag_p0, tag_out;
    assign tag_p0 = '{valid: launch, ch: filt_cnt, pix: pix_cnt};

    conv3_tag_pipe #(
        .STAGES (PIPE_LAT),
        .TAG_W  (tag_w(CH_W, PIX_W))
    ) u_tag_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (dp_valid),
        .tag_in   (tag_p0),
        .tag_out  (tag_out)
    );

    // ---- result label: registered when an advance retires a valid tag ----
    logic             res_valid_q;
    logic [CH_W-1:0]  res_ch_q;
    logic [PIX_W-1:0] res_pix_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_pix_q   <= '0;
        end else begin
            res_valid_q <= dp_valid && tag_out.valid;
            if (dp_valid && tag_out.valid) begin
                res_ch_q  <= tag_out.ch;
                res_pix_q <= tag_out.pix;
            end
        end
    end

`ifdef CONV3_SCHED_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (state == IDLE && start) begin
            stall_q <= '0;
        end else if (state == RUN && !bus.win_valid && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign bus.win_ready = win_ready;
    assign bus.dp_valid  = dp_valid;
    assign bus.dp_bubble = dp_bubble;
    assign bus.wt_addr   = filt_cnt;
    assign bus.res_valid = res_valid_q;
    assign bus.res_ch    = res_ch_q;
    assign bus.res_pix   = res_pix_q;
    assign busy          = (state != IDLE);
    assign frame_done    = done;

endmodule

// File: tb/tb_conv3_filter_sched.sv
// Self-checking bench for conv3_filter_sched against a launch/advance-count reference model.
module tb_conv3_filter_sched;

    localparam int NF    = 4;
    localparam int FP    = 2;
    localparam int PL    = 3;
    localparam int CH_W  = 2;
    localparam int PIX_W = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic busy, frame_done;
`ifdef CONV3_SCHED_PERF_EN
    logic [31:0] stall_cnt;
`endif

    conv3_filter_sched_if #(.CH_W(CH_W), .PIX_W(PIX_W)) bus ();

    conv3_filter_sched #(
        .NUM_FILTERS (NF),
        .FRAME_PIX   (FP),
        .PIPE_LAT    (PL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus.master),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef CONV3_SCHED_PERF_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: phase, next expected launch label, and a FIFO of
    // results due PL datapath advances after their launch.
    typedef struct {
        int ch;
        int pix;
        int due;
    } pend_t;

    pend_t pend[$];
    int    phase;          // 0 idle, 1 run, 2 flush
    int    m_ch, m_pix, flush_left, adv, stalls, launches;
    logic  exp_rv;
    int    exp_rch, exp_rpix;
    int    res_cnt, dut_done;
    int    vectors, miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        phase = 0; m_ch = 0; m_pix = 0; flush_left = 0; adv = 0;
        stalls = 0; exp_rv = 1'b0; exp_rch = 0; exp_rpix = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dp_valid"},  32'(bus.dp_valid),  0);
        chk({tag, "_win_ready"}, 32'(bus.win_ready), 0);
        chk({tag, "_dp_bubble"}, 32'(bus.dp_bubble), 0);
        chk({tag, "_wt_addr"},   32'(bus.wt_addr),   0);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 0);
        chk({tag, "_res_ch"},    32'(bus.res_ch),    0);
        chk({tag, "_res_pix"},   32'(bus.res_pix),   0);
        chk({tag, "_busy"},      32'(busy),          0);
        chk({tag, "_frame_done"},32'(frame_done),    0);
`ifdef CONV3_SCHED_PERF_EN
        chk({tag, "_stall_cnt"}, stall_cnt, 0);
`endif
    endtask

    // One clock: check outputs at the falling edge, then advance the model.
    task automatic cycle();
        logic launch;
        @(negedge clk);
        launch = (phase == 1) && bus.win_valid;
        chk("dp_valid",   32'(bus.dp_valid),  32'(launch || phase == 2));
        chk("win_ready",  32'(bus.win_ready), 32'(launch && m_ch == NF-1));
        chk("dp_bubble",  32'(bus.dp_bubble), 32'(phase == 2));
        chk("wt_addr",    32'(bus.wt_addr),   32'(m_ch));
        chk("busy",       32'(busy),          32'(phase != 0));
        chk("frame_done", 32'(frame_done),    32'(phase == 2 && flush_left == 1));
        chk("res_valid",  32'(bus.res_valid), 32'(exp_rv));
        if (exp_rv) begin
            chk("res_ch",  32'(bus.res_ch),  32'(exp_rch));
            chk("res_pix", 32'(bus.res_pix), 32'(exp_rpix));
            res_cnt++;
        end
`ifdef CONV3_SCHED_PERF_EN
        chk("stall_cnt", stall_cnt, 32'(stalls));
`endif
        if (frame_done === 1'b1) dut_done++;

        exp_rv = 1'b0;
        if (launch || phase == 2) begin
            if (pend.size() > 0 && pend[0].due == adv) begin
                exp_rv   = 1'b1;
                exp_rch  = pend[0].ch;
                exp_rpix = pend[0].pix;
                void'(pend.pop_front());
            end
            if (launch) pend.push_back('{m_ch, m_pix, adv + PL});
            adv++;
        end
        case (phase)
            0: if (start) begin phase = 1; m_ch = 0; m_pix = 0; stalls = 0; end
            1: begin
                if (launch) begin
                    launches++;
                    if (m_ch == NF-1) begin
                        m_ch = 0;
                        if (m_pix == FP-1) begin
                            m_pix = 0; phase = 2; flush_left = PL;
                        end else begin
                            m_pix++;
                        end
                    end else begin
                        m_ch++;
                    end
                end else begin
                    stalls++;
                end
            end
            default: begin
                if (flush_left == 1) phase = 0;
                flush_left--;
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    // Run one frame: pct = win_valid probability, optional stall gap after a
    // given launch count, optional start pulses while running.
    task automatic run_frame(input int pct, input int gap_after, input int gap_len,
                             input bit start_mid);
        int budget, r0, d0, gap_left;
        r0 = res_cnt; d0 = dut_done; gap_left = gap_len; launches = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        budget = 0;
        while (phase != 0 && budget < 400) begin
            if (launches == gap_after && gap_left > 0) begin
                bus.win_valid = 1'b0;
                gap_left--;
            end else begin
                bus.win_valid = ($urandom_range(99) < pct);
            end
            start = start_mid && (phase == 1) && ($urandom_range(3) == 0);
            cycle();
            budget++;
        end
        start = 1'b0;
        chk("frame_timeout", 32'(budget < 400), 1);
`ifdef CONV3_SCHED_PERF_EN
        chk("stall_at_done", stall_cnt, 32'(stalls));
`endif
        bus.win_valid = 1'b0;
        repeat (PL + 2) cycle();
        chk("res_total",  32'(res_cnt - r0),  32'(NF * FP));
        chk("done_total", 32'(dut_done - d0), 1);
    endtask

    initial begin
        vectors = 0; miscompares = 0; res_cnt = 0; dut_done = 0; launches = 0;
        bus.win_valid = 1'b0;
        model_reset();

        // Power-on reset
        #2 rst_n = 1'b0;
        #1 chk_all_zero("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) cycle();

        // T1: continuous windows
        run_frame(100, -1, 0, 1'b0);
        // T2: five-cycle stall after the second launch
        run_frame(100, 2, 5, 1'b0);
        // T6-style: seven stalls mid-frame (stall_cnt observed when enabled)
        run_frame(100, 3, 7, 1'b0);
        // Randomised window availability
        for (int i = 0; i < 4; i++) run_frame(60, -1, 0, 1'b0);
        // T3: start pulses while running are ignored, then an identical frame
        run_frame(100, -1, 0, 1'b1);
        run_frame(100, -1, 0, 1'b0);

        // T4: reset one cycle into the flush, tags still in flight
        launches = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        bus.win_valid = 1'b1;
        for (int b = 0; b < 100 && !(phase == 2 && flush_left == PL-1); b++) cycle();
        chk("t4_reached_flush", 32'(phase == 2 && pend.size() >= 2), 1);
        rst_n = 1'b0;
        #1 chk_all_zero("t4_rst");
        @(posedge clk);
        #1 chk_all_zero("t4_hold");
        @(negedge clk);
        rst_n = 1'b1;
        bus.win_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        repeat (PL + 3) cycle();
        run_frame(80, -1, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
